// File: rtl/mpc_rob_if.sv
// Bundle between the bank response crossbar, the channel response ports and mpc_rob.
// master drives allocation, bank responses and drain ready; slave is the reorder buffer.
interface mpc_rob_if #(
   parameter int NCHANNEL = 4,
   parameter int ROB_SIZE = 8,
   parameter int DATA_W   = 128
);
   localparam int CH_W  = (NCHANNEL > 1) ? $clog2(NCHANNEL) : 1;
   localparam int ROB_W = $clog2(ROB_SIZE);

   logic [NCHANNEL-1:0]        alloc_valid_i;
   logic [NCHANNEL-1:0]        alloc_ready_o;
   logic [NCHANNEL*ROB_W-1:0]  alloc_id_o;
   logic                       rsp_valid_i;
   logic [CH_W-1:0]            rsp_channel_i;
   logic [ROB_W-1:0]           rsp_id_i;
   logic [DATA_W-1:0]          rsp_data_i;
   logic [NCHANNEL-1:0]        out_valid_o;
   logic [NCHANNEL-1:0]        out_ready_i;
   logic [NCHANNEL*DATA_W-1:0] out_data_o;
   logic                       err_o;

   modport master (
      output alloc_valid_i, rsp_valid_i, rsp_channel_i, rsp_id_i, rsp_data_i, out_ready_i,
      input  alloc_ready_o, alloc_id_o, out_valid_o, out_data_o, err_o
   );

   modport slave (
      input  alloc_valid_i, rsp_valid_i, rsp_channel_i, rsp_id_i, rsp_data_i, out_ready_i,
      output alloc_ready_o, alloc_id_o, out_valid_o, out_data_o, err_o
   );
endinterface

// File: rtl/mpc_rob.sv
// Per-channel reorder buffer: responses land in tagged slots and drain in allocation order.
// Response visible one cycle after write; alloc stalls when a ring is full, head holds while out_ready is low.
module mpc_rob #(
   parameter int NCHANNEL = 4,
   parameter int ROB_SIZE = 8,
   parameter int DATA_W   = 128
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   mpc_rob_if.slave bus
);
   localparam int CH_W  = (NCHANNEL > 1) ? $clog2(NCHANNEL) : 1;
   localparam int ROB_W = $clog2(ROB_SIZE);

   localparam logic [ROB_W:0] PTR_ONE  = (ROB_W+1)'(1);
   localparam logic [ROB_W:0] PTR_FULL = (ROB_W+1)'(ROB_SIZE);

   logic [NCHANNEL-1:0] wr_hit;
   logic                err_q;

   for (genvar c = 0; c < NCHANNEL; c++) begin : g_ch
      logic [ROB_W:0]      head_q;
      logic [ROB_W:0]      tail_q;
      logic [ROB_W:0]      count;
      logic [ROB_W-1:0]    head_idx;
      logic [ROB_W-1:0]    tail_idx;
      logic [ROB_SIZE-1:0] alloc_q;
      logic [ROB_SIZE-1:0] filled_q;
      logic [DATA_W-1:0]   data_q [ROB_SIZE];
      logic                ready;
      logic                valid;
      logic                do_alloc;
      logic                do_drain;

      assign count    = tail_q - head_q;
      assign head_idx = head_q[ROB_W-1:0];
      assign tail_idx = tail_q[ROB_W-1:0];
      assign ready    = (count != PTR_FULL);
      assign valid    = filled_q[head_idx];
      assign do_alloc = bus.alloc_valid_i[c] & ready;
      assign do_drain = bus.out_ready_i[c] & valid;

      // A slot accepts exactly one response between its allocation and its drain.
      assign wr_hit[c] = bus.rsp_valid_i
                         && (bus.rsp_channel_i == CH_W'(c))
                         && alloc_q[bus.rsp_id_i]
                         && !filled_q[bus.rsp_id_i];

      assign bus.alloc_ready_o[c]                  = ready;
      assign bus.alloc_id_o[c*ROB_W +: ROB_W]      = tail_idx;
      assign bus.out_valid_o[c]                    = valid;
      assign bus.out_data_o[c*DATA_W +: DATA_W]    = data_q[head_idx];

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            head_q   <= '0;
            tail_q   <= '0;
            alloc_q  <= '0;
            filled_q <= '0;
         end else begin
            if (do_alloc) begin
               alloc_q[tail_idx] <= 1'b1;
               tail_q            <= tail_q + PTR_ONE;
            end
            if (wr_hit[c]) begin
               filled_q[bus.rsp_id_i] <= 1'b1;
            end
            // Drain needs a filled head and a write needs an unfilled slot, so they never collide.
            if (do_drain) begin
               alloc_q[head_idx]  <= 1'b0;
               filled_q[head_idx] <= 1'b0;
               head_q             <= head_q + PTR_ONE;
            end
         end
      end

      always_ff @(posedge clk_i) begin
         if (wr_hit[c]) begin
            data_q[bus.rsp_id_i] <= bus.rsp_data_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (bus.rsp_valid_i && (wr_hit == '0)) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err_o = err_q;
endmodule

// File: tb/tb_mpc_rob.sv
// Directed bench for mpc_rob with a counter-based reference model checked every cycle.
module tb_mpc_rob;
   localparam int NCH = 4;
   localparam int RS  = 8;
   localparam int DW  = 128;
   localparam int RW  = 3;
   localparam int CW  = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mpc_rob_if #(.NCHANNEL(NCH), .ROB_SIZE(RS), .DATA_W(DW)) bus ();

   mpc_rob #(.NCHANNEL(NCH), .ROB_SIZE(RS), .DATA_W(DW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Reference model: each ring is described by how many entries were ever allocated and drained.
   int            m_alloc [NCH];
   int            m_drain [NCH];
   bit            m_filled[NCH][RS];
   logic [DW-1:0] m_data  [NCH][RS];
   bit            m_err;
   int            drained [NCH];

   function automatic int outst(input int c);
      return m_alloc[c] - m_drain[c];
   endfunction

   function automatic bit pending(input int c, input int s);
      return ((s - m_drain[c]) & (RS-1)) < outst(c);
   endfunction

   function automatic bit exp_valid(input int c);
      return (outst(c) > 0) && m_filled[c][m_drain[c] % RS];
   endfunction

   always @(posedge clk) begin : model_upd
      bit a_ok [NCH];
      bit d_ok [NCH];
      int rc;
      int rs;
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            m_alloc[c] = 0;
            m_drain[c] = 0;
            for (int s = 0; s < RS; s++) m_filled[c][s] = 1'b0;
         end
         m_err = 1'b0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            a_ok[c] = bus.alloc_valid_i[c] && (outst(c) < RS);
            d_ok[c] = bus.out_ready_i[c] && exp_valid(c);
         end
         if (bus.rsp_valid_i) begin
            rc = int'(bus.rsp_channel_i);
            rs = int'(bus.rsp_id_i);
            if (rc < NCH && pending(rc, rs) && !m_filled[rc][rs]) begin
               m_filled[rc][rs] = 1'b1;
               m_data[rc][rs]   = bus.rsp_data_i;
            end else begin
               m_err = 1'b1;
            end
         end
         for (int c = 0; c < NCH; c++) begin
            if (d_ok[c]) begin
               m_filled[c][m_drain[c] % RS] = 1'b0;
               m_drain[c]++;
            end
            if (a_ok[c]) m_alloc[c]++;
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n) begin
         for (int c = 0; c < NCH; c++)
            if (bus.out_valid_o[c] && bus.out_ready_i[c]) drained[c]++;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int c = 0; c < NCH; c++) begin
            check($sformatf("alloc_ready[%0d]", c), DW'(bus.alloc_ready_o[c]), DW'(outst(c) < RS));
            check($sformatf("alloc_id[%0d]", c), DW'(bus.alloc_id_o[c*RW +: RW]), DW'(m_alloc[c] % RS));
            check($sformatf("out_valid[%0d]", c), DW'(bus.out_valid_o[c]), DW'(exp_valid(c)));
            if (exp_valid(c))
               check($sformatf("out_data[%0d]", c), bus.out_data_o[c*DW +: DW], m_data[c][m_drain[c] % RS]);
         end
         check("err", DW'(bus.err_o), DW'(m_err));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      bus.alloc_valid_i = '0;
      bus.rsp_valid_i   = 1'b0;
   endtask

   task automatic rsp(input int c, input int s, input logic [DW-1:0] d);
      bus.rsp_valid_i   = 1'b1;
      bus.rsp_channel_i = CW'(c);
      bus.rsp_id_i      = RW'(s);
      bus.rsp_data_i    = d;
   endtask

   function automatic logic [DW-1:0] odata(input int c);
      return bus.out_data_o[c*DW +: DW];
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int d0;
      int alloc_n;
      int rsp_n;
      bit took;

      bus.alloc_valid_i = '0;
      bus.rsp_valid_i   = 1'b0;
      bus.rsp_channel_i = '0;
      bus.rsp_id_i      = '0;
      bus.rsp_data_i    = '0;
      bus.out_ready_i   = '0;

      // Reset state
      rst_n = 1'b0;
      cyc();
      chk_en = 1'b1;
      cyc();
      rst_n = 1'b1;
      check("rst_alloc_ready", DW'(bus.alloc_ready_o), DW'(4'b1111));
      check("rst_out_valid", DW'(bus.out_valid_o), DW'(4'b0000));
      check("rst_err", DW'(bus.err_o), DW'(1'b0));
      check("rst_alloc_id", DW'(bus.alloc_id_o), DW'(12'h000));

      // Out-of-order return on channel 0
      for (int i = 0; i < 3; i++) begin
         bus.alloc_valid_i = 4'b0001;
         cyc();
      end
      check("ooo_next_id", DW'(bus.alloc_id_o[2:0]), DW'(3'd3));
      rsp(0, 2, 128'hC);
      cyc();
      check("ooo_wait_head", DW'(bus.out_valid_o[0]), DW'(1'b0));
      rsp(0, 0, 128'hA);
      cyc();
      check("ooo_first_valid", DW'(bus.out_valid_o[0]), DW'(1'b1));
      check("ooo_first_data", odata(0), 128'hA);
      rsp(0, 1, 128'hB);
      bus.out_ready_i = 4'b0001;
      cyc();
      check("ooo_second_data", odata(0), 128'hB);
      cyc();
      check("ooo_third_data", odata(0), 128'hC);
      cyc();
      bus.out_ready_i = 4'b0000;
      check("ooo_empty", DW'(bus.out_valid_o[0]), DW'(1'b0));
      check("ooo_no_err", DW'(bus.err_o), DW'(1'b0));

      // Full and wrap on channel 1
      d0      = drained[1];
      alloc_n = 0;
      for (int i = 0; i < RS; i++) begin
         bus.alloc_valid_i = 4'b0010;
         cyc();
         alloc_n++;
      end
      check("full_ready", DW'(bus.alloc_ready_o[1]), DW'(1'b0));
      bus.alloc_valid_i = 4'b0010;
      cyc();
      check("full_still_blocked", DW'(bus.alloc_ready_o[1]), DW'(1'b0));
      check("full_id_wrapped", DW'(bus.alloc_id_o[5:3]), DW'(3'd0));
      rsp(1, 0, 128'h100);
      cyc();
      rsp_n = 1;
      check("full_head_data", odata(1), 128'h100);
      bus.alloc_valid_i = 4'b0010;
      bus.out_ready_i   = 4'b0010;
      cyc();
      check("drain_frees_slot", DW'(bus.alloc_ready_o[1]), DW'(1'b1));
      check("wrap_alloc_id", DW'(bus.alloc_id_o[5:3]), DW'(3'd0));
      check("drain_next_empty", DW'(bus.out_valid_o[1]), DW'(1'b0));
      for (int k = 0; k < 200 && (drained[1] - d0) < 20; k++) begin
         took = (alloc_n < 20) && bus.alloc_ready_o[1];
         bus.alloc_valid_i[1] = (alloc_n < 20);
         if (rsp_n < alloc_n) begin
            rsp(1, rsp_n % RS, 128'h100 + DW'(rsp_n));
            rsp_n++;
         end
         cyc();
         if (took) alloc_n++;
      end
      bus.out_ready_i = 4'b0000;
      check("wrap_drained_20", DW'(drained[1] - d0), DW'(20));

      // Channel independence: channel 3 stalled while channel 0 drains
      bus.alloc_valid_i = 4'b1001;
      cyc();
      bus.alloc_valid_i = 4'b1001;
      cyc();
      rsp(3, 0, 128'h30);
      cyc();
      rsp(0, 3, 128'h03);
      cyc();
      check("ind_ch0_data", odata(0), 128'h03);
      rsp(3, 1, 128'h31);
      bus.out_ready_i = 4'b0001;
      cyc();
      check("ind_ch0_gap", DW'(bus.out_valid_o[0]), DW'(1'b0));
      check("ind_ch3_hold_a", odata(3), 128'h30);
      rsp(0, 4, 128'h04);
      cyc();
      check("ind_ch0_second", odata(0), 128'h04);
      check("ind_ch3_hold_b", odata(3), 128'h30);
      cyc();
      check("ind_ch3_valid", DW'(bus.out_valid_o[3]), DW'(1'b1));
      check("ind_ch3_hold_c", odata(3), 128'h30);
      bus.out_ready_i = 4'b1000;
      cyc();
      check("ind_ch3_next", odata(3), 128'h31);
      cyc();
      bus.out_ready_i = 4'b0000;
      check("ind_ch3_empty", DW'(bus.out_valid_o[3]), DW'(1'b0));

      // Protocol errors on channel 2
      rsp(2, 5, 128'hDEAD);
      cyc();
      check("err_unalloc", DW'(bus.err_o), DW'(1'b1));
      check("err_unalloc_ring", DW'(bus.alloc_id_o[8:6]), DW'(3'd0));
      check("err_unalloc_valid", DW'(bus.out_valid_o[2]), DW'(1'b0));
      bus.alloc_valid_i = 4'b0100;
      cyc();
      rsp(2, 0, 128'h11);
      cyc();
      rsp(2, 0, 128'h22);
      cyc();
      check("err_dup_keeps", odata(2), 128'h11);
      bus.alloc_valid_i = 4'b0100;
      rsp(2, 1, 128'h33);
      cyc();
      bus.out_ready_i = 4'b0100;
      cyc();
      bus.out_ready_i = 4'b0000;
      check("err_same_cycle_dropped", DW'(bus.out_valid_o[2]), DW'(1'b0));
      rsp(2, 1, 128'h44);
      cyc();
      check("err_retry_data", odata(2), 128'h44);
      bus.out_ready_i = 4'b0100;
      cyc();
      bus.out_ready_i = 4'b0000;
      check("err_sticky", DW'(bus.err_o), DW'(1'b1));

      // Reset in the middle of traffic
      bus.alloc_valid_i = 4'b0011;
      cyc();
      rsp(0, 5, 128'h77);
      bus.alloc_valid_i = 4'b0001;
      cyc();
      rst_n = 1'b0;
      bus.alloc_valid_i = 4'b1111;
      cyc();
      rst_n = 1'b1;
      check("mid_rst_alloc_id", DW'(bus.alloc_id_o), DW'(12'h000));
      check("mid_rst_ready", DW'(bus.alloc_ready_o), DW'(4'b1111));
      check("mid_rst_valid", DW'(bus.out_valid_o), DW'(4'b0000));
      check("mid_rst_err", DW'(bus.err_o), DW'(1'b0));

      // Backpressure on a full ring with alloc held high
      for (int i = 0; i < RS; i++) begin
         bus.alloc_valid_i = 4'b0001;
         cyc();
      end
      for (int i = RS - 1; i >= 0; i--) begin
         rsp(0, i, 128'h600 + DW'(i));
         cyc();
      end
      check("bp_full", DW'(bus.alloc_ready_o[0]), DW'(1'b0));
      check("bp_head", odata(0), 128'h600);
      alloc_n = RS;
      rsp_n   = RS;
      for (int k = 0; k < 80; k++) begin
         took = bus.alloc_ready_o[0];
         bus.alloc_valid_i[0] = 1'b1;
         bus.out_ready_i[0]   = 1'($urandom_range(0, 1));
         if (rsp_n < alloc_n) begin
            rsp(0, rsp_n % RS, 128'h600 + DW'(rsp_n));
            rsp_n++;
         end
         cyc();
         if (took) alloc_n++;
      end
      bus.out_ready_i = 4'b0000;
      cyc();
      check("bp_no_err", DW'(bus.err_o), DW'(1'b0));

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
